// File: rtl/keyboard_pkg.sv
// Shared definitions for the PS/2 keyboard controller: frame FSM states and scan codes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package keyboard_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_t;

    localparam logic [7:0] SC_SPACE = 8'h29;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: synchronizes ps2_clk/ps2_data, deframes start/8 data/parity/stop.
// Latency: o_vld/o_err pulse one clk after the stop-bit falling edge is detected.
// Backpressure: none; the keyboard cannot be stalled, each byte is a one-cycle pulse.
// Ports: clk, rst (async active-low), i_ps2_clk/i_ps2_data (async), o_byte, o_vld, o_err.
// Macro KEYBOARD_PARITY_CHK_EN: when defined, frames must carry odd parity over data+parity.
module ps2_rx
    import keyboard_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100_000
)(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_data,
    output logic [7:0] o_byte,
    output logic       o_vld,
    output logic       o_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES);

    logic            r_clk_s1, r_clk_s2, r_clk_prev;
    logic            r_dat_s1, r_dat_s2;
    ps2_state_t      r_state;
    logic [2:0]      r_bit_cnt;
    logic [7:0]      r_shift;
    logic [TW-1:0]   r_tmo;
    logic [7:0]      r_byte;
    logic            r_vld;
    logic            r_err;
    logic            w_fall;
    logic            w_accept;

    // Synchronizers idle high so a reset never looks like a start edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_clk_s1   <= 1'b1;
            r_clk_s2   <= 1'b1;
            r_clk_prev <= 1'b1;
            r_dat_s1   <= 1'b1;
            r_dat_s2   <= 1'b1;
        end else begin
            r_clk_s1   <= i_ps2_clk;
            r_clk_s2   <= r_clk_s1;
            r_clk_prev <= r_clk_s2;
            r_dat_s1   <= i_ps2_data;
            r_dat_s2   <= r_dat_s1;
        end
    end

    assign w_fall = r_clk_prev & ~r_clk_s2;

`ifdef KEYBOARD_PARITY_CHK_EN
    logic r_parity;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_parity <= 1'b0;
        else if (w_fall && r_state == ST_PARITY)
            r_parity <= r_dat_s2;
    end
    assign w_accept = r_dat_s2 & (^{r_shift, r_parity});
`else
    // Parity bit is clocked past in ST_PARITY but never judged.
    assign w_accept = r_dat_s2;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_bit_cnt <= 3'd0;
            r_shift   <= 8'd0;
            r_tmo     <= '0;
            r_byte    <= 8'd0;
            r_vld     <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_vld <= 1'b0;
            r_err <= 1'b0;
            if (w_fall) begin
                r_tmo <= '0;
                case (r_state)
                    ST_IDLE: begin
                        if (!r_dat_s2) begin
                            r_state   <= ST_DATA;
                            r_bit_cnt <= 3'd0;
                        end
                    end
                    ST_DATA: begin
                        // LSB arrives first, so shift in from the top.
                        r_shift   <= {r_dat_s2, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7)
                            r_state <= ST_PARITY;
                    end
                    ST_PARITY: r_state <= ST_STOP;
                    ST_STOP: begin
                        r_state <= ST_IDLE;
                        if (w_accept) begin
                            r_byte <= r_shift;
                            r_vld  <= 1'b1;
                        end else begin
                            r_err  <= 1'b1;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end else if (r_state != ST_IDLE) begin
                // Keyboard stalled mid-frame: drop the partial byte.
                if (r_tmo == TMO_MAX) begin
                    r_state <= ST_IDLE;
                    r_err   <= 1'b1;
                    r_tmo   <= '0;
                end else begin
                    r_tmo <= r_tmo + TW'(1);
                end
            end else begin
                r_tmo <= '0;
            end
        end
    end

    assign o_byte = r_byte;
    assign o_vld  = r_vld;
    assign o_err  = r_err;

endmodule

// File: rtl/keyboard_ctl_ps2.sv
// PS/2 keyboard controller: make/break decoder driving Space/Right/Left key levels.
// Latency: key levels change in the same clk as scan_valid (one clk after stop-bit edge).
// Backpressure: none; every accepted byte is decoded on its scan_valid pulse.
// Ports: clk, rst (async active-low), ps2_clk, ps2_data, key_space/right/left,
//        scan_code, scan_valid, frame_err. Macro KEYBOARD_PARITY_CHK_EN enables parity check.
module keyboard_ctl_ps2
    import keyboard_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100_000
)(
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       key_space,
    output logic       key_right,
    output logic       key_left,
    output logic [7:0] scan_code,
    output logic       scan_valid,
    output logic       frame_err
);

    logic [7:0] w_byte;
    logic       w_vld;
    logic       w_err;
    logic       w_is_key;
    logic       r_ext, r_brk;
    logic       r_space, r_right, r_left;

    ps2_rx #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
        .clk        (clk),
        .rst        (rst),
        .i_ps2_clk  (ps2_clk),
        .i_ps2_data (ps2_data),
        .o_byte     (w_byte),
        .o_vld      (w_vld),
        .o_err      (w_err)
    );

    assign w_is_key = w_vld && (w_byte != SC_EXT) && (w_byte != SC_BRK);

    // Key levels are resolved combinationally from the byte pulse so they
    // move in the same cycle as scan_valid; the registers hold them after.
    assign key_space = (w_is_key && !r_ext && w_byte == SC_SPACE) ? !r_brk : r_space;
    assign key_right = (w_is_key &&  r_ext && w_byte == SC_RIGHT) ? !r_brk : r_right;
    assign key_left  = (w_is_key &&  r_ext && w_byte == SC_LEFT)  ? !r_brk : r_left;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ext   <= 1'b0;
            r_brk   <= 1'b0;
            r_space <= 1'b0;
            r_right <= 1'b0;
            r_left  <= 1'b0;
        end else begin
            r_space <= key_space;
            r_right <= key_right;
            r_left  <= key_left;
            if (w_vld) begin
                if (w_byte == SC_EXT) begin
                    r_ext <= 1'b1;
                end else if (w_byte == SC_BRK) begin
                    r_brk <= 1'b1;
                end else begin
                    r_ext <= 1'b0;
                    r_brk <= 1'b0;
                end
            end
        end
    end

    assign scan_code  = w_byte;
    assign scan_valid = w_vld;
    assign frame_err  = w_err;

endmodule

// File: tb/tb_keyboard_ctl_ps2.sv
// Directed bench for keyboard_ctl_ps2: drives PS/2 frames and checks decoded outputs.
// Latency: n/a (testbench).
// Backpressure: n/a.
module tb_keyboard_ctl_ps2;
    localparam int TMO = 200;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       key_space, key_right, key_left;
    logic [7:0] scan_code;
    logic       scan_valid, frame_err;

    int errors = 0;
    int checks = 0;

    int         vld_cnt = 0;
    int         err_cnt = 0;
    int         left_hi_cnt = 0;
    logic [7:0] last_code = 8'h00;
    logic       space_at_vld = 1'b0;

    keyboard_ctl_ps2 #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk        (clk),
        .rst        (rst),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .key_space  (key_space),
        .key_right  (key_right),
        .key_left   (key_left),
        .scan_code  (scan_code),
        .scan_valid (scan_valid),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    // Record pulses away from the active edge.
    always @(negedge clk) begin
        if (scan_valid) begin
            vld_cnt++;
            last_code = scan_code;
            space_at_vld = key_space;
        end
        if (frame_err) err_cnt++;
        if (key_left) left_hi_cnt++;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic v);
        ps2_data = v;
        wait_clk(4);
        ps2_clk = 1'b0;
        wait_clk(8);
        ps2_clk = 1'b1;
        wait_clk(4);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par, input logic stop);
        logic [10:0] bits;
        bits = {stop, par, b, 1'b0};
        for (int i = 0; i < 11; i++) send_bit(bits[i]);
        ps2_data = 1'b1;
        wait_clk(8);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_frame(b, ~^b, 1'b1);
    endtask

    task automatic test_reset;
        rst = 1'b0;
        wait_clk(3);
        checks++; if (key_space !== 1'b0) begin errors++; $display("FAIL reset.key_space got %b want 0", key_space); end
        checks++; if (key_right !== 1'b0) begin errors++; $display("FAIL reset.key_right got %b want 0", key_right); end
        checks++; if (key_left !== 1'b0) begin errors++; $display("FAIL reset.key_left got %b want 0", key_left); end
        checks++; if (scan_code !== 8'h00) begin errors++; $display("FAIL reset.scan_code got %h want 00", scan_code); end
        checks++; if (scan_valid !== 1'b0) begin errors++; $display("FAIL reset.scan_valid got %b want 0", scan_valid); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset.frame_err got %b want 0", frame_err); end
        rst = 1'b1;
        wait_clk(3);
    endtask

    task automatic test_make_space;
        int v0;
        v0 = vld_cnt;
        send_byte(8'h29);
        checks++; if (vld_cnt - v0 !== 1) begin errors++; $display("FAIL make_space.vld_count got %0d want 1", vld_cnt - v0); end
        checks++; if (last_code !== 8'h29) begin errors++; $display("FAIL make_space.code got %h want 29", last_code); end
        checks++; if (space_at_vld !== 1'b1) begin errors++; $display("FAIL make_space.same_cycle got %b want 1", space_at_vld); end
        checks++; if (key_space !== 1'b1) begin errors++; $display("FAIL make_space.level got %b want 1", key_space); end
    endtask

    task automatic test_ext_right;
        int v0, l0;
        v0 = vld_cnt;
        l0 = left_hi_cnt;
        send_byte(8'hE0);
        send_byte(8'h74);
        checks++; if (key_right !== 1'b1) begin errors++; $display("FAIL ext_right.make got %b want 1", key_right); end
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h74);
        checks++; if (key_right !== 1'b0) begin errors++; $display("FAIL ext_right.break got %b want 0", key_right); end
        checks++; if (left_hi_cnt - l0 !== 0) begin errors++; $display("FAIL ext_right.left_quiet got %0d want 0", left_hi_cnt - l0); end
        checks++; if (vld_cnt - v0 !== 5) begin errors++; $display("FAIL ext_right.vld_count got %0d want 5", vld_cnt - v0); end
        checks++; if (key_space !== 1'b1) begin errors++; $display("FAIL ext_right.space_kept got %b want 1", key_space); end
    endtask

    task automatic test_typematic;
        for (int i = 0; i < 3; i++) begin
            send_byte(8'hE0);
            send_byte(8'h6B);
            checks++; if (key_left !== 1'b1) begin errors++; $display("FAIL typematic.rep%0d got %b want 1", i, key_left); end
        end
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h6B);
        checks++; if (key_left !== 1'b0) begin errors++; $display("FAIL typematic.release got %b want 0", key_left); end
    endtask

    task automatic test_break_space;
        send_byte(8'hF0);
        send_byte(8'h29);
        checks++; if (key_space !== 1'b0) begin errors++; $display("FAIL break_space.level got %b want 0", key_space); end
        checks++; if (scan_code !== 8'h29) begin errors++; $display("FAIL break_space.code got %h want 29", scan_code); end
    endtask

    task automatic test_unmapped;
        int v0;
        v0 = vld_cnt;
        send_byte(8'h1C);
        send_byte(8'hE0);
        send_byte(8'h29);   // extended 0x29 is not Space
        checks++; if (vld_cnt - v0 !== 3) begin errors++; $display("FAIL unmapped.vld_count got %0d want 3", vld_cnt - v0); end
        checks++; if ({key_space, key_right, key_left} !== 3'b000) begin errors++; $display("FAIL unmapped.keys got %b want 000", {key_space, key_right, key_left}); end
    endtask

    task automatic test_stop_err;
        int v0, e0;
        v0 = vld_cnt;
        e0 = err_cnt;
        send_frame(8'hF0, ~^8'hF0, 1'b0);
        checks++; if (err_cnt - e0 !== 1) begin errors++; $display("FAIL stop_err.err_count got %0d want 1", err_cnt - e0); end
        checks++; if (vld_cnt - v0 !== 0) begin errors++; $display("FAIL stop_err.vld_count got %0d want 0", vld_cnt - v0); end
        // A rejected F0 must not arm break, so this is a make.
        send_byte(8'h29);
        checks++; if (key_space !== 1'b1) begin errors++; $display("FAIL stop_err.brk_untouched got %b want 1", key_space); end
        send_byte(8'hF0);
        send_byte(8'h29);
        checks++; if (key_space !== 1'b0) begin errors++; $display("FAIL stop_err.release got %b want 0", key_space); end
    endtask

    task automatic test_parity;
        int v0, e0;
        v0 = vld_cnt;
        e0 = err_cnt;
        send_frame(8'h29, ^8'h29, 1'b1);   // even total parity
`ifdef KEYBOARD_PARITY_CHK_EN
        checks++; if (err_cnt - e0 !== 1) begin errors++; $display("FAIL parity.err_count got %0d want 1", err_cnt - e0); end
        checks++; if (vld_cnt - v0 !== 0) begin errors++; $display("FAIL parity.vld_count got %0d want 0", vld_cnt - v0); end
        checks++; if (key_space !== 1'b0) begin errors++; $display("FAIL parity.key_space got %b want 0", key_space); end
`else
        checks++; if (err_cnt - e0 !== 0) begin errors++; $display("FAIL parity.err_count got %0d want 0", err_cnt - e0); end
        checks++; if (vld_cnt - v0 !== 1) begin errors++; $display("FAIL parity.vld_count got %0d want 1", vld_cnt - v0); end
        checks++; if (key_space !== 1'b1) begin errors++; $display("FAIL parity.key_space got %b want 1", key_space); end
`endif
    endtask

    task automatic test_timeout;
        int v0, e0;
        logic [7:0] b;
        b = 8'h6B;
        v0 = vld_cnt;
        e0 = err_cnt;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(b[i]);
        ps2_data = 1'b1;
        wait_clk(TMO + 5);
        checks++; if (err_cnt - e0 !== 1) begin errors++; $display("FAIL timeout.err_count got %0d want 1", err_cnt - e0); end
        checks++; if (vld_cnt - v0 !== 0) begin errors++; $display("FAIL timeout.vld_count got %0d want 0", vld_cnt - v0); end
        send_byte(8'h6B);
        checks++; if (vld_cnt - v0 !== 1) begin errors++; $display("FAIL timeout.next_vld got %0d want 1", vld_cnt - v0); end
        checks++; if (last_code !== 8'h6B) begin errors++; $display("FAIL timeout.next_code got %h want 6b", last_code); end
        checks++; if (err_cnt - e0 !== 1) begin errors++; $display("FAIL timeout.no_extra_err got %0d want 1", err_cnt - e0); end
    endtask

    task automatic test_reset_midframe;
        int e0;
        send_byte(8'h29);
        checks++; if (key_space !== 1'b1) begin errors++; $display("FAIL rst_mid.pre got %b want 1", key_space); end
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        ps2_clk = 1'b0;
        wait_clk(3);
        rst = 1'b0;
        #1;
        checks++; if ({key_space, key_right, key_left} !== 3'b000) begin errors++; $display("FAIL rst_mid.keys got %b want 000", {key_space, key_right, key_left}); end
        checks++; if (scan_code !== 8'h00) begin errors++; $display("FAIL rst_mid.scan_code got %h want 00", scan_code); end
        checks++; if ({scan_valid, frame_err} !== 2'b00) begin errors++; $display("FAIL rst_mid.pulses got %b want 00", {scan_valid, frame_err}); end
        e0 = err_cnt;
        wait_clk(4);
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        rst = 1'b1;
        wait_clk(TMO + 20);
        checks++; if (err_cnt - e0 !== 0) begin errors++; $display("FAIL rst_mid.no_err got %0d want 0", err_cnt - e0); end
        send_byte(8'h29);
        checks++; if (key_space !== 1'b1) begin errors++; $display("FAIL rst_mid.after got %b want 1", key_space); end
        checks++; if (last_code !== 8'h29) begin errors++; $display("FAIL rst_mid.code got %h want 29", last_code); end
    endtask

    initial begin
        test_reset();
        test_make_space();
        test_ext_right();
        test_typematic();
        test_break_space();
        test_unmapped();
        test_stop_err();
        test_parity();
        test_timeout();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
